// File: rtl/multi_sprite_unit.sv
// multi_sprite_unit
//   Holds N_SPRITES moving square sprites. Once per frame, on the pixel that
//   starts the last visible line (pxl_x==0, pxl_y==HEIGHT-1), it sweeps every
//   sprite in turn and does three things for each one:
//     - retires a sprite that has been hit,
//     - applies thrust to sprite 0,
//     - moves the sprite by its velocity.
//   It also renders the sprites: each pixel gives a registered
//   Draw/Draw_id/RGB result one cycle later, and the lowest index wins.
//
//   Build option: define SPRITE_WRAP_EN for Asteroids-style wrap-around at the
//   screen edges. By default sprites clamp at the edges and bounce.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   pxl_x, pxl_y        current raster position
//   B, sin_val, cos_val thrust request and heading for sprite 0
//   collision           per-sprite hit pulses (ignored for inactive sprites)
//   spawn_*             spawn handshake, target id, position and velocity;
//                       spawn_ready is high only while idle
//   colors              {R,G,B} nibbles per sprite, sprite i at [12*i +: 12]
//   Red/Green/Blue      registered pixel colour (0 when nothing is drawn)
//   Draw, Draw_id       registered coverage flag and index of the winning sprite
module multi_sprite_unit #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int N_SPRITES    = 4,
  parameter int SIZE         = 64,
  parameter int FRAC_BITS    = 6,
  parameter int THRUST_SHIFT = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(WIDTH)-1:0]      pxl_x,
  input  logic [$clog2(HEIGHT)-1:0]     pxl_y,
  input  logic                          B,
  input  logic signed [17:0]            sin_val,
  input  logic signed [17:0]            cos_val,
  input  logic [N_SPRITES-1:0]          collision,
  input  logic                          spawn_valid,
  output logic                          spawn_ready,
  input  logic [3:0]                    spawn_id,
  input  logic [$clog2(WIDTH)-1:0]      spawn_x,
  input  logic [$clog2(HEIGHT)-1:0]     spawn_y,
  input  logic signed [15:0]            spawn_vx,
  input  logic signed [15:0]            spawn_vy,
  input  logic [12*N_SPRITES-1:0]       colors,
  output logic [3:0]                    Red,
  output logic [3:0]                    Green,
  output logic [3:0]                    Blue,
  output logic                          Draw,
  output logic [3:0]                    Draw_id
);

  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int PXW  = XW + FRAC_BITS;
  localparam int PYW  = YW + FRAC_BITS;
  localparam int PMAX = (PXW > PYW) ? PXW : PYW;
  // Working width for position arithmetic. It has room for the position,
  // a full 16-bit velocity, the sign and one carry bit.
  localparam int AW   = ((PMAX > 16) ? PMAX : 16) + 4;
  localparam int IDW  = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic signed [AW-1:0] SAT_HI = AW'(32767);
  localparam logic signed [AW-1:0] SAT_LO = -AW'(32768);

`ifdef SPRITE_WRAP_EN
  localparam logic signed [AW-1:0] RANGE_X = AW'(WIDTH << FRAC_BITS);
  localparam logic signed [AW-1:0] RANGE_Y = AW'(HEIGHT << FRAC_BITS);
`else
  localparam logic signed [AW-1:0] LIM_X = AW'((WIDTH - SIZE) << FRAC_BITS);
  localparam logic signed [AW-1:0] LIM_Y = AW'((HEIGHT - SIZE) << FRAC_BITS);
`endif

  function automatic logic signed [AW-1:0] sext16(input logic signed [15:0] v);
    return {{(AW-16){v[15]}}, v};
  endfunction

  function automatic logic signed [AW-1:0] sext18(input logic signed [17:0] v);
    return {{(AW-18){v[17]}}, v};
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [AW-1:0] v);
    if (v > SAT_HI)      return 16'sh7fff;
    else if (v < SAT_LO) return -16'sh8000;
    else                 return v[15:0];
  endfunction

`ifndef SPRITE_WRAP_EN
  // Negating -32768 overflows, so the result is saturated to +32767.
  function automatic logic signed [15:0] neg16(input logic signed [15:0] v);
    return sat16(-sext16(v));
  endfunction
`endif

  logic [1:0]              state;
  logic [IDW-1:0]          idx;
  logic                    trig_q;
  logic [N_SPRITES-1:0]    active;
  logic [N_SPRITES-1:0]    hit;
  logic [PXW-1:0]          pos_x [N_SPRITES];
  logic [PYW-1:0]          pos_y [N_SPRITES];
  logic signed [15:0]      vel_x [N_SPRITES];
  logic signed [15:0]      vel_y [N_SPRITES];

  logic                    frame_start;
  logic                    spawn_acc;
  logic signed [17:0]      thr_x, thr_y;
  logic signed [15:0]      vx_t, vy_t, vx_n, vy_n;
  logic signed [AW-1:0]    nx, ny;
  logic [PXW-1:0]          px_n;
  logic [PYW-1:0]          py_n;

  logic                    draw_c;
  logic [3:0]              draw_id_c;
  logic [11:0]             rgb_c;
  logic [XW+1:0]           sx;
  logic [YW+1:0]           sy;

  logic                    draw_p1;
  logic [3:0]              draw_id_p1;
  logic [11:0]             rgb_p1;

  assign frame_start = (pxl_x == XW'(0)) && (pxl_y == YW'(HEIGHT - 1));
  assign spawn_ready = (state == S_IDLE);
  assign spawn_acc   = spawn_valid && spawn_ready;
  assign thr_x       = cos_val >>> THRUST_SHIFT;
  assign thr_y       = sin_val >>> THRUST_SHIFT;

  // Motion step for the sprite that idx currently selects.
  always_comb begin
    vx_t = vel_x[idx];
    vy_t = vel_y[idx];
    if (idx == '0 && B) begin
      vx_t = sat16(sext16(vel_x[idx]) + sext18(thr_x));
      vy_t = sat16(sext16(vel_y[idx]) + sext18(thr_y));
    end
    vx_n = vx_t;
    vy_n = vy_t;
    nx = {{(AW-PXW){1'b0}}, pos_x[idx]} + sext16(vx_t);
    ny = {{(AW-PYW){1'b0}}, pos_y[idx]} + sext16(vy_t);
`ifdef SPRITE_WRAP_EN
    if (nx[AW-1])           nx = nx + RANGE_X;
    else if (nx >= RANGE_X) nx = nx - RANGE_X;
    if (ny[AW-1])           ny = ny + RANGE_Y;
    else if (ny >= RANGE_Y) ny = ny - RANGE_Y;
`else
    if (nx[AW-1]) begin
      nx   = '0;
      vx_n = neg16(vx_t);
    end else if (nx > LIM_X) begin
      nx   = LIM_X;
      vx_n = neg16(vx_t);
    end
    if (ny[AW-1]) begin
      ny   = '0;
      vy_n = neg16(vy_t);
    end else if (ny > LIM_Y) begin
      ny   = LIM_Y;
      vy_n = neg16(vy_t);
    end
`endif
    px_n = nx[PXW-1:0];
    py_n = ny[PYW-1:0];
  end

  // Pixel coverage. The loop runs from the highest index down, so the last
  // match it records is the lowest-index sprite.
  always_comb begin
    draw_c    = 1'b0;
    draw_id_c = '0;
    rgb_c     = '0;
    sx        = '0;
    sy        = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      sx = {2'b00, pos_x[i][PXW-1:FRAC_BITS]};
      sy = {2'b00, pos_y[i][PYW-1:FRAC_BITS]};
      if (active[i] &&
          ({2'b00, pxl_x} >= sx) && ({2'b00, pxl_x} < sx + (XW+2)'(SIZE)) &&
          ({2'b00, pxl_y} >= sy) && ({2'b00, pxl_y} < sy + (YW+2)'(SIZE))) begin
        draw_c    = 1'b1;
        draw_id_c = 4'(i);
        rgb_c     = colors[12*i +: 12];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      trig_q     <= 1'b0;
      active     <= '0;
      hit        <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
      end
      draw_p1    <= 1'b0;
      draw_id_p1 <= '0;
      rgb_p1     <= '0;
    end else begin
      // trig_q makes the sweep start on the first cycle of the trigger
      // pixel only, so a held pixel cannot start a second sweep.
      trig_q <= frame_start;
      case (state)
        S_IDLE: begin
          if (frame_start && !trig_q) begin
            state <= S_UPDATE;
            idx   <= '0;
          end
        end
        S_UPDATE: begin
          if (idx == IDW'(N_SPRITES - 1)) state <= S_DONE;
          else                            idx   <= idx + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      for (int i = 0; i < N_SPRITES; i++) begin
        if (spawn_acc && spawn_id == 4'(i)) begin
          // A spawn overrides a collision on the same sprite in the same cycle.
          pos_x[i]  <= {spawn_x, {FRAC_BITS{1'b0}}};
          pos_y[i]  <= {spawn_y, {FRAC_BITS{1'b0}}};
          vel_x[i]  <= spawn_vx;
          vel_y[i]  <= spawn_vy;
          active[i] <= 1'b1;
          hit[i]    <= 1'b0;
        end else begin
          if (collision[i] && active[i]) hit[i] <= 1'b1;
          if (state == S_UPDATE && idx == IDW'(i) && active[i]) begin
            if (hit[i]) begin
              active[i] <= 1'b0;
              hit[i]    <= 1'b0;
            end else begin
              pos_x[i] <= px_n;
              pos_y[i] <= py_n;
              vel_x[i] <= vx_n;
              vel_y[i] <= vy_n;
            end
          end
        end
      end

      // ---- stage p1: registered pixel result ----
      draw_p1    <= draw_c;
      draw_id_p1 <= draw_id_c;
      rgb_p1     <= rgb_c;
    end
  end

  assign Draw    = draw_p1;
  assign Draw_id = draw_id_p1;
  assign Red     = rgb_p1[11:8];
  assign Green   = rgb_p1[7:4];
  assign Blue    = rgb_p1[3:0];

endmodule
